// File: rtl/hdlc_pkg.sv
// Shared constants and state encoding for the HDLC receive deframer.
package hdlc_pkg;

  localparam logic [7:0] FLAG_PATTERN = 8'h7E;
  // a 0 followed by seven 1s, oldest bit in bit 0
  localparam logic [7:0] ABORT_PATTERN = 8'hFE;
  localparam int ABORT_ONES = 7;
  localparam int STUFF_ONES = 5;
  localparam int MIN_BYTES  = 3;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } rx_state_t;

endpackage

// File: rtl/hdlc_rx_deframer_if.sv
// Serial input and frame/byte status bundle of the HDLC receive deframer.
interface hdlc_rx_deframer_if;
  logic       RxEN;
  logic       Rx;
  logic       Rx_FlagDetect;
  logic       Rx_AbortDetect;
  logic       Rx_ValidFrame;
  logic       Rx_NewByte;
  logic [7:0] Rx_Data;
  logic       Rx_EoF;
  logic       Rx_FrameError;
  logic       Rx_AbortSignal;
  logic [7:0] Rx_FrameBytes;

  modport master (
    output RxEN, Rx,
    input  Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_NewByte, Rx_Data,
           Rx_EoF, Rx_FrameError, Rx_AbortSignal, Rx_FrameBytes
  );

  modport slave (
    input  RxEN, Rx,
    output Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_NewByte, Rx_Data,
           Rx_EoF, Rx_FrameError, Rx_AbortSignal, Rx_FrameBytes
  );
endinterface

// File: rtl/hdlc_rx_pattern_detect.sv
// Rx input register, 8-bit history window, flag/abort match and oldest-bit emission.
module hdlc_rx_pattern_detect
  import hdlc_pkg::*;
(
  input  logic Clk,
  input  logic Rst,
  input  logic en_i,
  input  logic rx_i,
  output logic flag_o,
  output logic abort_o,
  output logic bit_o,
  output logic bit_vld_o
);

  logic       rxd_q;
  logic [7:0] win_q, win_d;
  logic [7:0] vld_q, vld_d;
  logic       flag_q, flag_d;
  logic       abort_q, abort_d;

  // vld marks window slots holding bits received after the last delimiter,
  // so delimiter bits are never emitted as data
  always_comb begin
    win_d   = {rxd_q, win_q[7:1]};
    flag_d  = en_i && (win_d == FLAG_PATTERN);
    abort_d = en_i && (win_d == ABORT_PATTERN);
    vld_d   = (flag_d || abort_d || !en_i) ? 8'h00 : {1'b1, vld_q[7:1]};
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rxd_q   <= 1'b1;
      win_q   <= 8'hFF;
      vld_q   <= 8'h00;
      flag_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      rxd_q   <= rx_i;
      win_q   <= win_d;
      vld_q   <= vld_d;
      flag_q  <= flag_d;
      abort_q <= abort_d;
    end
  end

  assign flag_o    = flag_q;
  assign abort_o   = abort_q;
  assign bit_o     = win_q[0];
  assign bit_vld_o = vld_q[0];

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive front end: frame FSM, zero removal, byte assembly and frame status strobes.
//   state | meaning
//   HUNT  | waiting for a flag
//   SYNC  | flag(s) seen, waiting for first data bit
//   DATA  | delivering frame bits
module hdlc_rx_deframer
  import hdlc_pkg::*;
(
  input  logic               Clk,
  input  logic               Rst,
  hdlc_rx_deframer_if.slave  rx_if
);

  logic flag, abort, rx_bit, bit_vld;

  hdlc_rx_pattern_detect u_detect (
    .Clk       (Clk),
    .Rst       (Rst),
    .en_i      (rx_if.RxEN),
    .rx_i      (rx_if.Rx),
    .flag_o    (flag),
    .abort_o   (abort),
    .bit_o     (rx_bit),
    .bit_vld_o (bit_vld)
  );

  rx_state_t  state_q, state_d;
  logic [2:0] ones_q, ones_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] data_q, data_d;
  logic [7:0] bytes_q, bytes_d;
  logic       newbyte_q, newbyte_d;
  logic       eof_q, eof_d;
  logic       ferr_q, ferr_d;
  logic       abrt_q, abrt_d;
  logic       take_bit;
  logic [2:0] ones_base, cnt_base;

  always_comb begin
    state_d   = state_q;
    ones_d    = ones_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    bytes_d   = bytes_q;
    newbyte_d = 1'b0;
    eof_d     = 1'b0;
    ferr_d    = 1'b0;
    abrt_d    = 1'b0;
    take_bit  = 1'b0;
    // the first bit of a frame starts from fresh counters
    ones_base = (state_q == DATA) ? ones_q   : 3'd0;
    cnt_base  = (state_q == DATA) ? bitcnt_q : 3'd0;

    if (!rx_if.RxEN) begin
      state_d  = HUNT;
      ones_d   = 3'd0;
      bitcnt_d = 3'd0;
      shreg_d  = 8'h00;
      data_d   = 8'h00;
      bytes_d  = 8'h00;
    end else begin
      unique case (state_q)
        HUNT: if (flag) state_d = SYNC;
        SYNC: begin
          if (abort) begin
            state_d = HUNT;
          end else if (bit_vld) begin
            state_d  = DATA;
            bytes_d  = 8'h00;
            take_bit = 1'b1;
          end
        end
        DATA: begin
          if (flag) begin
            state_d = SYNC;
            eof_d   = 1'b1;
            ferr_d  = (bitcnt_q != 3'd0) || (bytes_q < 8'(MIN_BYTES));
          end else if (abort) begin
            state_d = HUNT;
            eof_d   = 1'b1;
            abrt_d  = 1'b1;
          end else if (bit_vld) begin
            take_bit = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (take_bit) begin
      if (!rx_bit && (ones_base == 3'(STUFF_ONES))) begin
        ones_d = 3'd0;
      end else begin
        ones_d   = rx_bit ? ((ones_base == 3'd7) ? 3'd7 : ones_base + 3'd1) : 3'd0;
        shreg_d  = {rx_bit, shreg_q[7:1]};
        bitcnt_d = cnt_base + 3'd1;
        if (cnt_base == 3'd7) begin
          data_d    = shreg_d;
          newbyte_d = 1'b1;
          if (bytes_d != 8'hFF) bytes_d = bytes_d + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= HUNT;
      ones_q    <= 3'd0;
      bitcnt_q  <= 3'd0;
      shreg_q   <= 8'h00;
      data_q    <= 8'h00;
      bytes_q   <= 8'h00;
      newbyte_q <= 1'b0;
      eof_q     <= 1'b0;
      ferr_q    <= 1'b0;
      abrt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ones_q    <= ones_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      bytes_q   <= bytes_d;
      newbyte_q <= newbyte_d;
      eof_q     <= eof_d;
      ferr_q    <= ferr_d;
      abrt_q    <= abrt_d;
    end
  end

  assign rx_if.Rx_FlagDetect  = flag;
  assign rx_if.Rx_AbortDetect = abort;
  assign rx_if.Rx_ValidFrame  = (state_q == DATA);
  assign rx_if.Rx_NewByte     = newbyte_q;
  assign rx_if.Rx_Data        = data_q;
  assign rx_if.Rx_EoF         = eof_q;
  assign rx_if.Rx_FrameError  = ferr_q;
  assign rx_if.Rx_AbortSignal = abrt_q;
  assign rx_if.Rx_FrameBytes  = bytes_q;

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Self-checking bench for hdlc_rx_deframer: stuffing transmitter, frame table, event scoreboard.
module tb_hdlc_rx_deframer;

  logic Clk = 1'b0;
  logic Rst;

  hdlc_rx_deframer_if rxi();

  hdlc_rx_deframer dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .rx_if (rxi)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int          nbytes;
    logic [31:0] bytes;
    int          nextra;
    logic [3:0]  extra;
    bit          end_abort;
    bit          post;
    bit          exp_err;
    bit          exp_abt;
    int          exp_cnt;
  } row_t;

  typedef struct { logic [7:0] d; int c; } nb_t;
  typedef struct { int c; bit err; bit abt; int cnt; } eof_t;

  int   exp_flag[$];
  int   exp_abort[$];
  nb_t  exp_nb[$];
  eof_t exp_eof[$];

  int n_pass = 0, n_total = 0;
  int n_fl = 0, n_ab = 0, n_nb = 0, n_eof = 0, n_vf = 0;

  logic [7:0] hist;
  int ones, last_cyc, last_data_cyc;
  row_t tbl[5];

  task automatic chk(input string nm, input bit ok, input int act, input int exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // predicts detector pulses from the sent history
  task automatic send_bit(input logic b);
    rxi.Rx   = b;
    last_cyc = cyc;
    hist     = {b, hist[7:1]};
    if (hist == 8'h7E) exp_flag.push_back(cyc + 2);
    if (hist == 8'hFE) exp_abort.push_back(cyc + 2);
    @(posedge Clk); #1;
  endtask

  task automatic send_data_bit(input logic b);
    send_bit(b);
    last_data_cyc = last_cyc;
    if (b) begin
      ones++;
      if (ones == 5) begin
        send_bit(1'b0);
        ones = 0;
      end
    end else begin
      ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input bit expect_it);
    nb_t e;
    for (int i = 0; i < 8; i++) send_data_bit(v[i]);
    e.d = v;
    e.c = last_data_cyc + 10;
    if (expect_it) exp_nb.push_back(e);
  endtask

  task automatic send_flag();
    send_bit(1'b0);
    repeat (6) send_bit(1'b1);
    send_bit(1'b0);
    ones = 0;
  endtask

  task automatic run_row(input row_t r);
    eof_t ev;
    send_flag();
    for (int i = 0; i < r.nbytes; i++) send_byte(r.bytes[8*i +: 8], 1'b1);
    for (int i = 0; i < r.nextra; i++) send_data_bit(r.extra[i]);
    if (r.end_abort) begin
      send_bit(1'b0);
      repeat (7) send_bit(1'b1);
      ones = 0;
    end else begin
      send_flag();
    end
    ev.c   = last_cyc + 3;
    ev.err = r.exp_err;
    ev.abt = r.exp_abt;
    ev.cnt = r.exp_cnt;
    exp_eof.push_back(ev);
    if (r.post) send_byte(8'h5A, 1'b0);
    repeat (16) send_bit(1'b1);
  endtask

  always @(negedge Clk) begin
    int   e;
    nb_t  nbe;
    eof_t eve;
    if (!Rst) begin
      if (rxi.Rx_ValidFrame) n_vf++;
      if (rxi.Rx_FlagDetect) begin
        n_fl++;
        if (exp_flag.size() == 0) chk("flag_unexpected", 1'b0, cyc, -1);
        else begin
          e = exp_flag.pop_front();
          chk("flag_cycle", cyc == e, cyc, e);
        end
      end
      if (rxi.Rx_AbortDetect) begin
        n_ab++;
        if (exp_abort.size() == 0) chk("abort_unexpected", 1'b0, cyc, -1);
        else begin
          e = exp_abort.pop_front();
          chk("abort_cycle", cyc == e, cyc, e);
        end
      end
      if (rxi.Rx_NewByte) begin
        n_nb++;
        if (exp_nb.size() == 0) chk("newbyte_unexpected", 1'b0, int'(rxi.Rx_Data), -1);
        else begin
          nbe = exp_nb.pop_front();
          chk("newbyte_data", rxi.Rx_Data == nbe.d, int'(rxi.Rx_Data), int'(nbe.d));
          chk("newbyte_cycle", cyc == nbe.c, cyc, nbe.c);
          chk("vf_at_newbyte", rxi.Rx_ValidFrame == 1'b1, int'(rxi.Rx_ValidFrame), 1);
        end
      end
      if (rxi.Rx_EoF) begin
        n_eof++;
        if (exp_eof.size() == 0) chk("eof_unexpected", 1'b0, cyc, -1);
        else begin
          eve = exp_eof.pop_front();
          chk("eof_cycle", cyc == eve.c, cyc, eve.c);
          chk("eof_frame_error", rxi.Rx_FrameError == eve.err, int'(rxi.Rx_FrameError), int'(eve.err));
          chk("eof_abort_signal", rxi.Rx_AbortSignal == eve.abt, int'(rxi.Rx_AbortSignal), int'(eve.abt));
          chk("eof_frame_bytes", int'(rxi.Rx_FrameBytes) == eve.cnt, int'(rxi.Rx_FrameBytes), eve.cnt);
          chk("vf_at_eof", rxi.Rx_ValidFrame == 1'b0, int'(rxi.Rx_ValidFrame), 0);
        end
      end
    end
  end

  function automatic int outs_word();
    return int'({rxi.Rx_FlagDetect, rxi.Rx_AbortDetect, rxi.Rx_ValidFrame, rxi.Rx_NewByte,
                 rxi.Rx_EoF, rxi.Rx_FrameError, rxi.Rx_AbortSignal, rxi.Rx_Data, rxi.Rx_FrameBytes});
  endfunction

  initial begin
    int fl0, ab0, nb0, eof0, vf0;

    tbl[0] = '{4, 32'h81F03CA5, 0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4};
    tbl[1] = '{3, 32'h003412FF, 0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3};
    tbl[2] = '{2, 32'h0000AA55, 0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 2};
    tbl[3] = '{3, 32'h00030201, 4, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0, 3};
    tbl[4] = '{2, 32'h00002211, 0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2};

    hist = 8'hFF;
    ones = 0;
    last_cyc = 0;
    last_data_cyc = 0;
    Rst = 1'b0;
    rxi.RxEN = 1'b1;
    rxi.Rx = 1'b1;
    #2 Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1 chk("reset_outputs", outs_word() == 0, outs_word(), 0);
    @(negedge Clk) Rst = 1'b0;
    @(posedge Clk); #1;

    // idle line
    fl0 = n_fl; ab0 = n_ab; nb0 = n_nb; eof0 = n_eof; vf0 = n_vf;
    repeat (40) send_bit(1'b1);
    chk("idle_flag", n_fl == fl0, n_fl - fl0, 0);
    chk("idle_abort", n_ab == ab0, n_ab - ab0, 0);
    chk("idle_newbyte", n_nb == nb0, n_nb - nb0, 0);
    chk("idle_eof", n_eof == eof0, n_eof - eof0, 0);
    chk("idle_validframe", n_vf == vf0, n_vf - vf0, 0);

    for (int r = 0; r < 5; r++) run_row(tbl[r]);

    // async reset in the middle of a frame
    send_flag();
    send_byte(8'h21, 1'b1);
    send_byte(8'h43, 1'b1);
    send_data_bit(1'b0);
    send_data_bit(1'b1);
    send_data_bit(1'b1);
    send_data_bit(1'b0);
    chk("vf_before_rst", rxi.Rx_ValidFrame == 1'b1, int'(rxi.Rx_ValidFrame), 1);
    rxi.Rx = 1'b1;
    #1 Rst = 1'b1;
    #1 chk("rst_midframe_outputs", outs_word() == 0, outs_word(), 0);
    Rst = 1'b0;
    exp_flag.delete();
    exp_abort.delete();
    exp_nb.delete();
    exp_eof.delete();
    hist = 8'hFF;
    ones = 0;
    @(posedge Clk); #1;
    repeat (12) send_bit(1'b1);
    run_row(tbl[0]);

    repeat (20) send_bit(1'b1);
    chk("left_flag", exp_flag.size() == 0, exp_flag.size(), 0);
    chk("left_abort", exp_abort.size() == 0, exp_abort.size(), 0);
    chk("left_newbyte", exp_nb.size() == 0, exp_nb.size(), 0);
    chk("left_eof", exp_eof.size() == 0, exp_eof.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
